// File: rtl/filter_rom_loader_pkg.sv
// Shared definitions for the filter image loader: FSM states, the 12-bit pixel
// layout the overlay reads back, target bank codes and header framing.
package filter_rom_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_PIX_LO = 3'd2,
        ST_PIX_HI = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_e;

    // Pixel word layout; bit 9 is the background flag, or part of TRANS in style 3.
    localparam int PIX_W       = 12;
    localparam int PIX_R_LSB   = 0;
    localparam int PIX_R_MSB   = 2;
    localparam int PIX_G_LSB   = 3;
    localparam int PIX_G_MSB   = 5;
    localparam int PIX_B_LSB   = 6;
    localparam int PIX_B_MSB   = 8;
    localparam int PIX_BG_BIT  = 9;
    localparam int PIX_TR_LSB  = 9;
    localparam int PIX_TR_MSB  = 11;

    localparam logic [1:0] BANK_FACE0 = 2'd0;
    localparam logic [1:0] BANK_FACE1 = 2'd1;
    localparam logic [1:0] BANK_EYE   = 2'd2;

    localparam logic [2:0] HDR_LEN = 3'd4;

    // A header is usable only when both dimensions are non-zero and the area fits.
    function automatic logic size_ok(input logic [9:0]  w,
                                     input logic [9:0]  h,
                                     input logic [19:0] prod,
                                     input logic [20:0] limit);
        return (w != 10'd0) && (h != 10'd0) && ({1'b0, prod} <= limit);
    endfunction

endpackage

// File: rtl/byte_pair_packer.sv
// Joins a low byte and the low nibble of a following high byte into one 12-bit
// pixel word, flagging each completed word for exactly one cycle.
module byte_pair_packer
    import filter_rom_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             lo_en,
    input  logic             hi_en,
    input  logic [7:0]       byte_in,
    output logic             word_valid,
    output logic [PIX_W-1:0] word
);

    logic [7:0]       lo_r;
    logic [PIX_W-1:0] word_r;
    logic             word_valid_r;

    // Low byte holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_r <= 8'd0;
        end else if (clear) begin
            lo_r <= 8'd0;
        end else if (lo_en) begin
            lo_r <= byte_in;
        end else begin
            lo_r <= lo_r;
        end
    end

    // Assembled word and its one-cycle strobe; the word holds between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_r       <= 12'd0;
            word_valid_r <= 1'b0;
        end else if (clear) begin
            word_r       <= word_r;
            word_valid_r <= 1'b0;
        end else if (hi_en) begin
            word_r       <= {byte_in[3:0], lo_r};
            word_valid_r <= 1'b1;
        end else begin
            word_r       <= word_r;
            word_valid_r <= 1'b0;
        end
    end

    assign word       = word_r;
    assign word_valid = word_valid_r;

endmodule

// File: rtl/filter_rom_loader.sv
// Parses a size header from a byte stream, then writes 12-bit pixels in raster
// order into the selected filter RAM bank and publishes the image dimensions.
module filter_rom_loader
    import filter_rom_loader_pkg::*;
#(
    parameter int ADDR_W    = 20,
    parameter int MAX_DEPTH = 131072
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              start,
    input  logic [1:0]        bank_sel,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [1:0]        wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic [9:0]        width,
    output logic [9:0]        height,
    output logic              loaded,
    output logic              err
);

    localparam logic [20:0] DEPTH_LIMIT = 21'(MAX_DEPTH);

    state_e            state_r;
    state_e            state_nxt_s;
    logic              acc_s;
    logic              hdr_last_s;
    logic              pix_last_s;
    logic              size_ok_s;
    logic              lo_en_s;
    logic              hi_en_s;
    logic [1:0]        hdr_cnt_r;
    logic [9:0]        width_r;
    logic [9:0]        height_r;
    logic [9:0]        h_full_s;
    logic [19:0]       product_s;
    logic [19:0]       total_r;
    logic [19:0]       pix_cnt_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [1:0]        wr_bank_r;
    logic              loaded_r;
    logic              err_r;

    assign in_ready = (state_r == ST_HDR) || (state_r == ST_PIX_LO) || (state_r == ST_PIX_HI);
    assign acc_s    = in_valid && in_ready;

    // The size check sees the height MSBs straight from the byte being accepted.
    assign h_full_s   = {in_data[1:0], height_r[7:0]};
    assign product_s  = {10'd0, width_r} * {10'd0, h_full_s};
    assign size_ok_s  = size_ok(width_r, h_full_s, product_s, DEPTH_LIMIT);
    assign hdr_last_s = ({1'b0, hdr_cnt_r} == (HDR_LEN - 3'd1));
    assign pix_last_s = ((pix_cnt_r + 20'd1) == total_r);
    assign lo_en_s    = acc_s && (state_r == ST_PIX_LO) && !start;
    assign hi_en_s    = acc_s && (state_r == ST_PIX_HI) && !start;

    // State register.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; start restarts from any state.
    always_comb begin
        state_nxt_s = state_r;
        if (start) begin
            state_nxt_s = ST_HDR;
        end else begin
            case (state_r)
                ST_IDLE: state_nxt_s = ST_IDLE;
                ST_HDR: begin
                    if (acc_s && hdr_last_s) begin
                        state_nxt_s = size_ok_s ? ST_PIX_LO : ST_ERR;
                    end else begin
                        state_nxt_s = ST_HDR;
                    end
                end
                ST_PIX_LO: begin
                    if (acc_s) begin
                        state_nxt_s = ST_PIX_HI;
                    end else begin
                        state_nxt_s = ST_PIX_LO;
                    end
                end
                ST_PIX_HI: begin
                    if (acc_s) begin
                        state_nxt_s = pix_last_s ? ST_DONE : ST_PIX_LO;
                    end else begin
                        state_nxt_s = ST_PIX_HI;
                    end
                end
                ST_DONE: state_nxt_s = ST_DONE;
                ST_ERR:  state_nxt_s = ST_ERR;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Header byte counter and image dimensions.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            hdr_cnt_r <= 2'd0;
            width_r   <= 10'd0;
            height_r  <= 10'd0;
            total_r   <= 20'd0;
        end else if (start) begin
            hdr_cnt_r <= 2'd0;
        end else if (acc_s && (state_r == ST_HDR)) begin
            hdr_cnt_r <= hdr_cnt_r + 2'd1;
            case (hdr_cnt_r)
                2'd0:    width_r[7:0]  <= in_data;
                2'd1:    width_r[9:8]  <= in_data[1:0];
                2'd2:    height_r[7:0] <= in_data;
                2'd3: begin
                    height_r[9:8] <= in_data[1:0];
                    total_r       <= product_s;
                end
                default: hdr_cnt_r <= 2'd0;
            endcase
        end else begin
            hdr_cnt_r <= hdr_cnt_r;
        end
    end

    // Pixel counter, write address and bank selection.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            pix_cnt_r <= 20'd0;
            wr_addr_r <= '0;
            wr_bank_r <= BANK_FACE0;
        end else if (start) begin
            pix_cnt_r <= 20'd0;
            wr_bank_r <= bank_sel;
        end else if (hi_en_s) begin
            pix_cnt_r <= pix_cnt_r + 20'd1;
            wr_addr_r <= ADDR_W'(pix_cnt_r);
        end else begin
            pix_cnt_r <= pix_cnt_r;
        end
    end

    // Completion and rejection flags; loaded rises with the final write.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            loaded_r <= 1'b0;
            err_r    <= 1'b0;
        end else if (start) begin
            loaded_r <= 1'b0;
            err_r    <= 1'b0;
        end else if (acc_s && (state_r == ST_HDR) && hdr_last_s) begin
            err_r    <= !size_ok_s;
        end else if (hi_en_s && pix_last_s) begin
            loaded_r <= 1'b1;
        end else begin
            loaded_r <= loaded_r;
        end
    end

    byte_pair_packer u_packer (
        .clk        (iCLK),
        .rst_n      (iRST_N),
        .clear      (start),
        .lo_en      (lo_en_s),
        .hi_en      (hi_en_s),
        .byte_in    (in_data),
        .word_valid (wr_en),
        .word       (wr_data)
    );

    assign wr_addr = wr_addr_r;
    assign wr_bank = wr_bank_r;
    assign width   = width_r;
    assign height  = height_r;
    assign loaded  = loaded_r;
    assign err     = err_r;

endmodule

// File: tb/tb_filter_rom_loader.sv
// Directed bench for filter_rom_loader: header parsing, pixel packing, size
// rejection, stalls, restart and reset behaviour.
module tb_filter_rom_loader;

    logic        iCLK = 1'b0;
    logic        iRST_N;
    logic        start;
    logic [1:0]  bank_sel;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [1:0]  wr_bank;
    logic [19:0] wr_addr;
    logic [11:0] wr_data;
    logic [9:0]  width;
    logic [9:0]  height;
    logic        loaded;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    logic [19:0] mon_addr[$];
    logic [11:0] mon_data[$];
    logic [1:0]  mon_bank[$];
    logic        mon_loaded[$];

    filter_rom_loader dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .start(start), .bank_sel(bank_sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
        .width(width), .height(height), .loaded(loaded), .err(err)
    );

    always #5 iCLK = ~iCLK;

    // Record every write strobe seen at the falling edge.
    always @(negedge iCLK) begin
        if (wr_en) begin
            mon_addr.push_back(wr_addr);
            mon_data.push_back(wr_data);
            mon_bank.push_back(wr_bank);
            mon_loaded.push_back(loaded);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge iCLK); #1;
        end
    endtask

    task automatic pulse_start(input logic [1:0] b);
        in_valid = 1'b0;
        start    = 1'b1;
        bank_sel = b;
        @(posedge iCLK); #1;
        start    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit done;
        done = 1'b0;
        if (gap > 0) idle(gap);
        in_data  = b;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge iCLK);
            if (in_ready) done = 1'b1;
            @(posedge iCLK); #1;
        end
        if (!done) chk("handshake_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic send_hdr(input logic [7:0] b0, b1, b2, b3);
        send_byte(b0, 0);
        send_byte(b1, 0);
        send_byte(b2, 0);
        send_byte(b3, 0);
    endtask

    initial begin
        int base;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [11:0] exp_d;

        iRST_N = 1'b0; start = 1'b0; bank_sel = 2'd0; in_data = 8'd0; in_valid = 1'b0;
        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_wr_en",    {31'd0, wr_en},    32'd0);
        chk("rst_wr_addr",  {12'd0, wr_addr},  32'd0);
        chk("rst_wr_data",  {20'd0, wr_data},  32'd0);
        chk("rst_wr_bank",  {30'd0, wr_bank},  32'd0);
        chk("rst_width",    {22'd0, width},    32'd0);
        chk("rst_height",   {22'd0, height},   32'd0);
        chk("rst_loaded",   {31'd0, loaded},   32'd0);
        chk("rst_err",      {31'd0, err},      32'd0);
        iRST_N = 1'b1;
        idle(2);
        chk("idle_in_ready", {31'd0, in_ready}, 32'd0);

        // 4x2 image at full rate; first pixel 0x3A,0xF5 -> 0x53A.
        pulse_start(2'd1);
        chk("t1_in_ready_hdr", {31'd0, in_ready}, 32'd1);
        base = mon_addr.size();
        send_hdr(8'h04, 8'h00, 8'h02, 8'h00);
        for (int i = 0; i < 8; i++) begin
            lo = (i == 0) ? 8'h3A : 8'(17 * i);
            hi = (i == 0) ? 8'hF5 : 8'(8'hF0 | i);
            send_byte(lo, 0);
            send_byte(hi, 0);
        end
        idle(3);
        chk("t1_nwrites", mon_addr.size() - base, 32'd8);
        chk("t1_first_data", {20'd0, mon_data[base]}, 32'h53A);
        for (int i = 0; i < 8; i++) begin
            exp_d = (i == 0) ? 12'h53A : {4'(i), 8'(17 * i)};
            chk($sformatf("t1_addr%0d", i), {12'd0, mon_addr[base+i]}, i);
            chk($sformatf("t1_data%0d", i), {20'd0, mon_data[base+i]}, {20'd0, exp_d});
            chk($sformatf("t1_bank%0d", i), {30'd0, mon_bank[base+i]}, 32'd1);
            chk($sformatf("t1_loaded_at%0d", i), {31'd0, mon_loaded[base+i]}, (i == 7) ? 32'd1 : 32'd0);
        end
        @(negedge iCLK);
        chk("t1_width",  {22'd0, width},  32'd4);
        chk("t1_height", {22'd0, height}, 32'd2);
        chk("t1_loaded", {31'd0, loaded}, 32'd1);
        chk("t1_err",    {31'd0, err},    32'd0);
        chk("t1_ready",  {31'd0, in_ready}, 32'd0);

        // Width zero is rejected.
        pulse_start(2'd0);
        chk("t2_loaded_cleared", {31'd0, loaded}, 32'd0);
        base = mon_addr.size();
        send_hdr(8'h00, 8'h00, 8'h02, 8'h00);
        @(negedge iCLK);
        chk("t2_err",    {31'd0, err},      32'd1);
        chk("t2_ready",  {31'd0, in_ready}, 32'd0);
        chk("t2_height", {22'd0, height},   32'd2);
        idle(4);
        chk("t2_nwrites", mon_addr.size() - base, 32'd0);

        // 512x512 exceeds the depth limit.
        pulse_start(2'd0);
        chk("t3_err_cleared", {31'd0, err}, 32'd0);
        base = mon_addr.size();
        send_hdr(8'h00, 8'h02, 8'h00, 8'h02);
        @(negedge iCLK);
        chk("t3_err",    {31'd0, err},    32'd1);
        chk("t3_width",  {22'd0, width},  32'd512);
        chk("t3_height", {22'd0, height}, 32'd512);
        idle(4);
        chk("t3_nwrites", mon_addr.size() - base, 32'd0);

        // 512x256 sits exactly on the limit and is accepted.
        pulse_start(2'd0);
        send_hdr(8'h00, 8'h02, 8'h00, 8'h01);
        @(negedge iCLK);
        chk("t4_err",   {31'd0, err},      32'd0);
        chk("t4_ready", {31'd0, in_ready}, 32'd1);

        // 3x3 image with input stalls.
        pulse_start(2'd0);
        base = mon_addr.size();
        send_hdr(8'h03, 8'h00, 8'h03, 8'h00);
        for (int i = 0; i < 9; i++) begin
            send_byte(8'(33 * i + 5), (2 * i + 1) % 4);
            send_byte(8'(8'h80 | (i + 3)), i % 3);
        end
        idle(3);
        chk("t5_nwrites", mon_addr.size() - base, 32'd9);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("t5_addr%0d", i), {12'd0, mon_addr[base+i]}, i);
            chk($sformatf("t5_data%0d", i), {20'd0, mon_data[base+i]}, {20'd0, 4'(i + 3), 8'(33 * i + 5)});
        end
        chk("t5_loaded", {31'd0, loaded}, 32'd1);

        // Restart a 4x4 load after 3 pixels and a dangling low byte.
        pulse_start(2'd1);
        chk("t6_loaded_cleared", {31'd0, loaded}, 32'd0);
        chk("t6_bank1", {30'd0, wr_bank}, 32'd1);
        base = mon_addr.size();
        send_hdr(8'h04, 8'h00, 8'h04, 8'h00);
        for (int i = 0; i < 3; i++) begin
            send_byte(8'(8'h40 + i), 0);
            send_byte(8'(i), 0);
        end
        send_byte(8'h99, 0);
        idle(2);
        chk("t6_partial_writes", mon_addr.size() - base, 32'd3);
        pulse_start(2'd2);
        chk("t6_bank2",  {30'd0, wr_bank},  32'd2);
        chk("t6_loaded", {31'd0, loaded},   32'd0);
        chk("t6_ready",  {31'd0, in_ready}, 32'd1);
        base = mon_addr.size();
        send_hdr(8'h02, 8'h00, 8'h01, 8'h00);
        send_byte(8'h5C, 0);
        send_byte(8'h0E, 0);
        send_byte(8'h6D, 0);
        send_byte(8'h3F, 0);
        idle(3);
        chk("t6_nwrites", mon_addr.size() - base, 32'd2);
        chk("t6_addr0",   {12'd0, mon_addr[base]},   32'd0);
        chk("t6_addr1",   {12'd0, mon_addr[base+1]}, 32'd1);
        chk("t6_data0",   {20'd0, mon_data[base]},   32'hE5C);
        chk("t6_data1",   {20'd0, mon_data[base+1]}, 32'hF6D);
        chk("t6_wbank",   {30'd0, mon_bank[base+1]}, 32'd2);
        chk("t6_last_loaded", {31'd0, mon_loaded[base+1]}, 32'd1);
        chk("t6_width",   {22'd0, width},  32'd2);
        chk("t6_height",  {22'd0, height}, 32'd1);

        // Reset in the middle of a pixel.
        pulse_start(2'd1);
        base = mon_addr.size();
        send_hdr(8'h02, 8'h00, 8'h01, 8'h00);
        send_byte(8'h11, 0);
        in_valid = 1'b0;
        iRST_N   = 1'b0;
        @(negedge iCLK);
        chk("t7_rst_ready", {31'd0, in_ready}, 32'd0);
        chk("t7_rst_width", {22'd0, width},    32'd0);
        chk("t7_rst_bank",  {30'd0, wr_bank},  32'd0);
        iRST_N = 1'b1;
        in_data  = 8'h02;
        in_valid = 1'b1;
        repeat (3) @(posedge iCLK);
        #1;
        in_valid = 1'b0;
        idle(2);
        chk("t7_no_writes", mon_addr.size() - base, 32'd0);
        chk("t7_idle_ready", {31'd0, in_ready}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/filter_rom_loader.md
# filter_rom_loader

Loads a filter image into the overlay's on-chip filter memory. It accepts a byte stream (valid/ready) containing a 4-byte size header followed by 12-bit pixel words. It then writes the pixels in raster order at addresses `x + width*y`, in the 12-bit format the overlay reads back (`[2:0]` R / `[5:3]` G / `[8:6]` B / `[9]` background flag, or `[11:9]` transparency for style 3). It sits between the image source (UART/SD byte reader) and the filter RAM write port, and publishes the `width`/`height` the overlay uses.

## Interface
- `ADDR_W`, 20, write address width (matches overlay read address).
- `MAX_DEPTH`, 131072, largest accepted `width*height`; larger images are rejected.
- `iCLK`  in  1  system clock.
- `iRST_N`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse; begins a load (also aborts and restarts a load in progress).
- `bank_sel`  in  2  target memory (0 = face ROM0, 1 = face ROM1, 2 = eye ROM); latched on `start`.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  byte accepted when `in_valid && in_ready`.
- `wr_en`  out  1  write strobe to filter RAM.
- `wr_bank`  out  2  latched `bank_sel`.
- `wr_addr`  out  ADDR_W  write address.
- `wr_data`  out  12  pixel word.
- `width`  out  10  image width, held after header.
- `height`  out  10  image height, held after header.
- `loaded`  out  1  high after a complete successful load until next `start`.
- `err`  out  1  high after a rejected header until next `start`.

## Operation
- States: IDLE, HDR, PIX_LO, PIX_HI, DONE, ERR.
- IDLE: `in_ready = 0`; a `start` pulse moves to HDR, clears the byte counter, `loaded`, and `err`, and latches `bank_sel`.
- HDR: four bytes in order W[7:0], W[9:8] (in byte bits [1:0]), H[7:0], H[9:8]; unused bits are ignored.
- After the 4th header byte, check the size:
  - if `width == 0`, `height == 0`, or `width*height > MAX_DEPTH`, go to ERR;
  - otherwise go to PIX_LO with pixel counter = 0 and total = `width*height` (20-bit product).
- PIX_LO: the accepted byte becomes `data[7:0]`; go to PIX_HI.
- PIX_HI: the accepted byte's bits [3:0] become `data[11:8]`, and bits [7:4] are ignored. A write is issued with `wr_addr` = pixel counter and `wr_data` = the assembled word, and the counter increments.
  - If the counter reaches total, go to DONE.
  - Otherwise return to PIX_LO.
- Addresses are sequential, so no multiplier is needed for the address.
- DONE: `loaded = 1`, `in_ready = 0`; stays until `start`.
- ERR: `err = 1`, `in_ready = 0`; `width`/`height` hold the rejected values; stays until `start`.
- `in_ready` is combinational from state only (high in HDR, PIX_LO, PIX_HI), independent of `in_valid`.
- `start` in any state restarts at HDR. A partially written image is abandoned, and `loaded` drops in the same edge.
- `in_valid` low stalls the FSM with no state change; there is no timeout.

## Timing
- Reset values: state IDLE, `in_ready` 0, `wr_en` 0, `wr_bank` 0, `wr_addr` 0, `wr_data` 0, `width` 0, `height` 0, `loaded` 0, `err` 0.
- `wr_en`/`wr_addr`/`wr_data` are registered:
  - the write is asserted for exactly one cycle, the cycle after the high byte's handshake;
  - `wr_addr`/`wr_data` hold their value when `wr_en` is 0.
- Maximum throughput is one byte per cycle, giving one pixel write every 2 cycles.
- `width`/`height` update on the edge that accepts the respective byte.
- `loaded` rises on the same edge that issues the final write, so it is visible together with the last `wr_en`.
- Reset asserted mid-load forces IDLE immediately. No write is issued after reset.

## Structure
- A shared package holds:
  - the state enum;
  - the pixel field positions (R/G/B/BG/TRANS bit ranges) shared with the overlay;
  - bank codes;
  - the header length constant (4).
- One sub-module: `byte_pair_packer` (assembles the low/high bytes into the 12-bit word and emits a one-cycle `word_valid`); the FSM and counters stay in the top.

## Test plan
- Header `0x04,0x00,0x02,0x00` + 8 pixels (16 bytes) at full rate -> 8 writes, `wr_addr` 0..7, `width` = 4, `height` = 2, `loaded` rises with the write at address 7.
- Pixel bytes `0x3A,0xF5` -> `wr_data` = `0x53A` (upper nibble of the high byte ignored).
- Header width 0 -> `err` = 1 after the 4th byte, no `wr_en`, `in_ready` = 0.
- Header 512x512 (`0x00,0x02,0x00,0x02`) with `MAX_DEPTH` = 131072 -> `err` = 1, no writes.
- Random `in_valid` gaps on a 3x3 image -> exactly 9 writes at addresses 0..8 with correct data order; no write during stalls.
- `start` after 3 pixels of a 4x4 load, `bank_sel` changed to 2 -> `loaded` = 0, `wr_bank` = 2, the new header is parsed, and the new image writes from address 0.
